temp_fan_ctrl: RTL and testbench
================================

# temp_fan_ctrl

Consumer for the one-hot temperature class produced by the temperature decoder (baja / normal / alta / peligrosa). Qualifies the class against glitches, drives a fan PWM output whose duty cycle follows the qualified class, and drives a blinking alarm while the class is peligrosa. It sits between the temperature decoder and the board fan/alarm pins.

## Interface
- STABLE_CYCLES, 4: consecutive identical samples required before a class is accepted (>= 2)
- PWM_BITS, 4: PWM counter width; PWM period = 2^PWM_BITS cycles (>= 2)
- BLINK_BITS, 4: alarm blink counter width; blink period = 2^BLINK_BITS cycles (>= 2)

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- y_in  in  4  class from decoder: 1000 baja, 0100 normal, 0010 alta, 0001 peligrosa
- class_q  out  4  qualified class, registered
- fan_pwm  out  1  fan drive, registered
- alarm  out  1  alarm drive, registered
- code_err  out  1  y_in is not exactly one-hot, registered

## Operation
- Reset values: class_q=0100, candidate=0100, stable count=0, pwm_cnt=0, duty_q=2^(PWM_BITS-1), fan_pwm=0, blink_cnt=0, alarm=0, code_err=0.
- Qualifier, every edge:
  - y_in != candidate: candidate<=y_in, count<=0.
  - else count != STABLE_CYCLES-1: count<=count+1.
  - else: if candidate is one-hot, class_q<=candidate (count holds at STABLE_CYCLES-1).
- A non-one-hot candidate (0000, multiple bits set) never reaches class_q; class_q holds its last valid value.
- code_err <= (y_in not one-hot), every edge, no qualification.
- Duty (PWM_BITS+1 bits): baja 0, normal 2^(PWM_BITS-1), alta 3*2^(PWM_BITS-2), peligrosa 2^PWM_BITS.
- pwm_cnt: free-running, increments every edge, wraps from 2^PWM_BITS-1 to 0.
- duty_q loads the duty of class_q only on the edge where pwm_cnt==2^PWM_BITS-1; no mid-period duty change.
- fan_pwm <= (pwm_cnt < duty_q), zero-extended compare; duty 0 gives constant 0, duty 2^PWM_BITS gives constant 1.
- Alarm: class_q != 0001: blink_cnt<=0, alarm<=0. class_q==0001: blink_cnt<=blink_cnt+1 (wraps), alarm<=~blink_cnt[BLINK_BITS-1].

## Timing
- Class latency: y_in changes and is sampled at edge E0; class_q updates at edge E(STABLE_CYCLES), i.e. 5th sampling edge for default.
- A change lasting fewer than STABLE_CYCLES+1 sampling edges is discarded; returning to the old value restarts the count.
- Duty latency: the new class takes effect in the first PWM period starting after class_q changes (up to 2^PWM_BITS+1 cycles).
- fan_pwm lags pwm_cnt by one cycle; the high phase starts the cycle after pwm_cnt==0.
- Alarm: alarm=1 one edge after class_q becomes 0001. It is then high 2^(BLINK_BITS-1) cycles and low 2^(BLINK_BITS-1) cycles, repeating.
- Alarm clears to 0 one edge after class_q leaves 0001.
- code_err latency: 1 edge.
- reset asserted mid-operation forces all registers to reset values without waiting for a clock. After release, the first edge resumes normal operation with pwm_cnt counting from 0.

## Test plan
- Reset, y_in=0100 held: all outputs 0 and class_q=0100 during reset. After release, fan_pwm is high 8 of every 16 cycles and alarm stays 0.
- Glitch rejection: y_in=1000 for 3 edges then 0100, so class_q stays 0100. y_in=1000 held, so class_q=1000 at the 5th sampling edge and fan_pwm=0 from the next period on.
- y_in=0010 held: class_q=0010 and fan_pwm high 12 of every 16 cycles. The duty switches only at the pwm_cnt wrap, and no period has a truncated or merged pulse.
- y_in=0001 held: fan_pwm constant 1 and alarm toggles 8 high / 8 low. Then y_in=0100: alarm=0 one edge after class_q=0100 and fan returns to 8/16.
- y_in=0110 then 0000 for 10 cycles: code_err=1 from the edge after each, class_q unchanged. y_in=0100: code_err=0 after one edge.
- In peligrosa with alarm=1, assert reset between edges: alarm, fan_pwm and code_err go 0 and class_q goes 0100 immediately. After release, behaviour matches the first scenario.

Source files
------------

// File: rtl/temp_fan_ctrl.sv
// temp_fan_ctrl: qualifies the one-hot temperature class from the decoder,
// drives a fan PWM whose duty follows the qualified class, and blinks an
// alarm while the class is peligrosa.
module temp_fan_ctrl #(
    parameter int STABLE_CYCLES = 4,
    parameter int PWM_BITS      = 4,
    parameter int BLINK_BITS    = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] y_in,
    output logic [3:0] class_q,
    output logic       fan_pwm,
    output logic       alarm,
    output logic       code_err
);

    localparam int CNT_W  = (STABLE_CYCLES > 2) ? $clog2(STABLE_CYCLES) : 1;
    localparam int DUTY_W = PWM_BITS + 1;

    localparam logic [CNT_W-1:0]    CNT_LAST    = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [PWM_BITS-1:0] PWM_LAST    = {PWM_BITS{1'b1}};
    localparam logic [DUTY_W-1:0]   DUTY_BAJA   = '0;
    localparam logic [DUTY_W-1:0]   DUTY_NORMAL = DUTY_W'(1 << (PWM_BITS - 1));
    localparam logic [DUTY_W-1:0]   DUTY_ALTA   = DUTY_W'(3 << (PWM_BITS - 2));
    localparam logic [DUTY_W-1:0]   DUTY_PELIG  = DUTY_W'(1 << PWM_BITS);

    localparam logic [3:0] CLS_BAJA   = 4'b1000;
    localparam logic [3:0] CLS_NORMAL = 4'b0100;
    localparam logic [3:0] CLS_ALTA   = 4'b0010;
    localparam logic [3:0] CLS_PELIG  = 4'b0001;

    logic [3:0]            candidate;
    logic [CNT_W-1:0]      stable_cnt;
    logic [PWM_BITS-1:0]   pwm_cnt;
    logic [DUTY_W-1:0]     duty_q;
    logic [DUTY_W-1:0]     duty_next;
    logic [BLINK_BITS-1:0] blink_cnt;
    logic                  y_onehot;
    logic                  cand_onehot;

    function automatic logic is_onehot(input logic [3:0] v);
        return (v != 4'b0000) && ((v & (v - 4'd1)) == 4'b0000);
    endfunction

    assign y_onehot    = is_onehot(y_in);
    assign cand_onehot = is_onehot(candidate);

    // Glitch filter: a class must be seen on STABLE_CYCLES+1 consecutive edges
    // and be one-hot before it is published on class_q.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            candidate  <= CLS_NORMAL;
            stable_cnt <= '0;
            class_q    <= CLS_NORMAL;
        end else if (y_in != candidate) begin
            candidate  <= y_in;
            stable_cnt <= '0;
        end else if (stable_cnt != CNT_LAST) begin
            stable_cnt <= stable_cnt + 1'b1;
        end else if (cand_onehot) begin
            class_q    <= candidate;
        end
    end

    // Encoding check on the raw input, no filtering.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            code_err <= 1'b0;
        end else begin
            code_err <= ~y_onehot;
        end
    end

    // Duty cycle that corresponds to the currently qualified class.
    always_comb begin
        duty_next = duty_q;
        case (class_q)
            CLS_BAJA:   duty_next = DUTY_BAJA;
            CLS_NORMAL: duty_next = DUTY_NORMAL;
            CLS_ALTA:   duty_next = DUTY_ALTA;
            CLS_PELIG:  duty_next = DUTY_PELIG;
            default:    duty_next = duty_q;
        endcase
    end

    // Free-running PWM counter; duty is only reloaded at the period boundary
    // so a period is never truncated or merged with the next.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pwm_cnt <= '0;
            duty_q  <= DUTY_NORMAL;
            fan_pwm <= 1'b0;
        end else begin
            pwm_cnt <= pwm_cnt + 1'b1;
            if (pwm_cnt == PWM_LAST) begin
                duty_q <= duty_next;
            end
            fan_pwm <= ({1'b0, pwm_cnt} < duty_q);
        end
    end

    // Alarm blinks with a 50% duty while peligrosa, starting in the high phase.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            blink_cnt <= '0;
            alarm     <= 1'b0;
        end else if (class_q != CLS_PELIG) begin
            blink_cnt <= '0;
            alarm     <= 1'b0;
        end else begin
            blink_cnt <= blink_cnt + 1'b1;
            alarm     <= ~blink_cnt[BLINK_BITS-1];
        end
    end

endmodule

// File: tb/tb_temp_fan_ctrl.sv
// tb_temp_fan_ctrl: scoreboard bench for temp_fan_ctrl. A behavioural model
// predicts the registered outputs at every rising edge; predictions are
// compared against the DUT on the following falling edge.
module tb_temp_fan_ctrl;

    localparam int STABLE = 4;
    localparam int PWMB   = 4;
    localparam int BLINKB = 4;
    localparam int PERIOD = 1 << PWMB;
    localparam int BLINKP = 1 << BLINKB;

    logic       clk;
    logic       reset;
    logic [3:0] y_in;
    logic [3:0] class_q;
    logic       fan_pwm;
    logic       alarm;
    logic       code_err;

    typedef struct {
        logic [3:0] cls;
        logic       fan;
        logic       alm;
        logic       err;
    } expT;

    expT sbQueue[$];

    int nChecks = 0;
    int nFails  = 0;

    // model state
    logic [3:0] mCls;
    logic [3:0] mLast;
    int         mRun;
    int         mPhase;
    int         mDuty;
    int         mAlarmCycles;

    temp_fan_ctrl #(
        .STABLE_CYCLES(STABLE),
        .PWM_BITS(PWMB),
        .BLINK_BITS(BLINKB)
    ) dut (
        .clk(clk),
        .reset(reset),
        .y_in(y_in),
        .class_q(class_q),
        .fan_pwm(fan_pwm),
        .alarm(alarm),
        .code_err(code_err)
    );

    // 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic int dutyOf(input logic [3:0] c);
        case (c)
            4'b1000: return 0;
            4'b0100: return PERIOD / 2;
            4'b0010: return (PERIOD * 3) / 4;
            4'b0001: return PERIOD;
            default: return -1;
        endcase
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        nChecks++;
        if (actual !== expected) begin
            nFails++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, actual, expected, $time);
        end
    endtask

    // Reference model: tracks run length of identical samples, PWM phase and
    // time spent in peligrosa, and pushes the predicted outputs per edge.
    always @(posedge clk or posedge reset) begin
        expT e;
        if (reset) begin
            mCls         = 4'b0100;
            mLast        = 4'b0100;
            mRun         = 1;
            mPhase       = 0;
            mDuty        = PERIOD / 2;
            mAlarmCycles = 0;
            sbQueue.delete();
        end else begin
            e.err = ($countones(y_in) != 1);
            e.fan = (mPhase < mDuty);
            e.alm = (mCls == 4'b0001) ? ((mAlarmCycles % BLINKP) < (BLINKP / 2)) : 1'b0;
            mAlarmCycles = (mCls == 4'b0001) ? mAlarmCycles + 1 : 0;
            if (mPhase == PERIOD - 1) mDuty = dutyOf(mCls);
            mPhase = (mPhase + 1) % PERIOD;
            if (y_in == mLast) begin
                if (mRun < 1000) mRun = mRun + 1;
            end else begin
                mLast = y_in;
                mRun  = 1;
            end
            if (mRun >= STABLE + 1 && $countones(mLast) == 1) mCls = mLast;
            e.cls = mCls;
            sbQueue.push_back(e);
        end
    end

    // Compare predictions against the DUT away from the rising edge.
    always @(negedge clk) begin
        expT e;
        if (!reset && sbQueue.size() > 0) begin
            e = sbQueue.pop_front();
            checkOutput("class_q", 32'(class_q), 32'(e.cls));
            checkOutput("fan_pwm", 32'(fan_pwm), 32'(e.fan));
            checkOutput("alarm", 32'(alarm), 32'(e.alm));
            checkOutput("code_err", 32'(code_err), 32'(e.err));
        end
    end

    task automatic applyStimulus(input logic [3:0] y, input int cycles);
        y_in = y;
        repeat (cycles) @(negedge clk);
    endtask

    task automatic measureHigh(output int fanHigh, output int alarmHigh);
        fanHigh   = 0;
        alarmHigh = 0;
        for (int i = 0; i < PERIOD; i++) begin
            @(negedge clk);
            if (fan_pwm) fanHigh++;
            if (alarm) alarmHigh++;
        end
    endtask

    initial begin
        int fh;
        int ah;
        reset = 1'b1;
        y_in  = 4'b0100;
        repeat (2) @(negedge clk);
        checkOutput("rstClass", 32'(class_q), 32'h4);
        checkOutput("rstFan", 32'(fan_pwm), 32'h0);
        checkOutput("rstAlarm", 32'(alarm), 32'h0);
        checkOutput("rstErr", 32'(code_err), 32'h0);
        reset = 1'b0;

        // normal after reset
        applyStimulus(4'b0100, 20);
        measureHigh(fh, ah);
        checkOutput("normalFanHigh", 32'(fh), 32'd8);
        checkOutput("normalAlarmHigh", 32'(ah), 32'd0);

        // glitch of 3 edges is discarded
        applyStimulus(4'b1000, 3);
        applyStimulus(4'b0100, 10);
        checkOutput("glitchHold", 32'(class_q), 32'h4);

        // baja accepted, fan off
        applyStimulus(4'b1000, 40);
        checkOutput("bajaClass", 32'(class_q), 32'h8);
        measureHigh(fh, ah);
        checkOutput("bajaFanHigh", 32'(fh), 32'd0);

        // alta: 12 of 16
        applyStimulus(4'b0010, 40);
        measureHigh(fh, ah);
        checkOutput("altaFanHigh", 32'(fh), 32'd12);

        // peligrosa: fan constant on, alarm 8/16
        applyStimulus(4'b0001, 40);
        measureHigh(fh, ah);
        checkOutput("peligFanHigh", 32'(fh), 32'd16);
        checkOutput("peligAlarmHigh", 32'(ah), 32'd8);

        // back to normal
        applyStimulus(4'b0100, 40);
        measureHigh(fh, ah);
        checkOutput("backFanHigh", 32'(fh), 32'd8);
        checkOutput("backAlarmHigh", 32'(ah), 32'd0);

        // bad encodings
        applyStimulus(4'b0110, 10);
        checkOutput("errMulti", 32'(code_err), 32'h1);
        applyStimulus(4'b0000, 10);
        checkOutput("errZero", 32'(code_err), 32'h1);
        checkOutput("errClassHold", 32'(class_q), 32'h4);
        applyStimulus(4'b0100, 10);
        checkOutput("errClear", 32'(code_err), 32'h0);

        // reset mid-operation while the alarm is high
        applyStimulus(4'b0001, 30);
        for (int i = 0; i < 2 * BLINKP && alarm !== 1'b1; i++) @(negedge clk);
        checkOutput("alarmBeforeReset", 32'(alarm), 32'h1);
        #2 reset = 1'b1;
        #1;
        checkOutput("asyncClass", 32'(class_q), 32'h4);
        checkOutput("asyncFan", 32'(fan_pwm), 32'h0);
        checkOutput("asyncAlarm", 32'(alarm), 32'h0);
        checkOutput("asyncErr", 32'(code_err), 32'h0);
        y_in = 4'b0100;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        applyStimulus(4'b0100, 20);
        measureHigh(fh, ah);
        checkOutput("postRstFanHigh", 32'(fh), 32'd8);
        checkOutput("postRstAlarmHigh", 32'(ah), 32'd0);

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nChecks, nFails);
        $finish;
    end

endmodule
